// File: rtl/rf_wb_scoreboard.sv
// Write-back arbiter and RAW/WAW hazard scoreboard in front of the core register file.
// Round-robin grants NUM_WB requesters onto one registered write port and gates issue on busy registers.
module rf_wb_scoreboard #(
    parameter int NUM_WB     = 2,
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         iss_valid,
    input  logic [ADDR_WIDTH-1:0]        iss_rs1,
    input  logic [ADDR_WIDTH-1:0]        iss_rs2,
    input  logic [ADDR_WIDTH-1:0]        iss_rd,
    input  logic                         iss_rd_we,
    output logic                         iss_ready,
    output logic [ADDR_WIDTH-1:0]        rf_raddr1,
    output logic [ADDR_WIDTH-1:0]        rf_raddr2,
    input  logic [NUM_WB-1:0]            wb_valid,
    input  logic [NUM_WB*ADDR_WIDTH-1:0] wb_addr,
    input  logic [NUM_WB*DATA_WIDTH-1:0] wb_data,
    output logic [NUM_WB-1:0]            wb_ready,
    output logic                         rf_wen,
    output logic [ADDR_WIDTH-1:0]        rf_waddr,
    output logic [DATA_WIDTH-1:0]        rf_wdata,
    output logic                         wb_err
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam int PTR_W    = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;

    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_next;
    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      ptr_next;
    logic [PTR_W-1:0]      cand;
    logic [PTR_W-1:0]      grant_idx;
    logic                  grant_any;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic [DATA_WIDTH-1:0] grant_data;
    logic                  rs1_hazard;
    logic                  rs2_hazard;
    logic                  rd_hazard;
    logic                  set_en;
    logic                  err_hit;

    assign rf_raddr1 = iss_rs1;
    assign rf_raddr2 = iss_rs2;

    assign rs1_hazard = (iss_rs1 != '0) && busy[iss_rs1];
    assign rs2_hazard = (iss_rs2 != '0) && busy[iss_rs2];
    assign rd_hazard  = iss_rd_we && (iss_rd != '0) && busy[iss_rd];
    assign iss_ready  = !(rs1_hazard || rs2_hazard || rd_hazard);

    assign set_en = iss_valid && iss_ready && iss_rd_we && (iss_rd != '0);

    // Round-robin: scan requesters starting at ptr, first valid one wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_WB; k++) begin
            cand = PTR_W'((int'(ptr) + k) % NUM_WB);
            if (!grant_any && wb_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
    end

    always_comb begin
        wb_ready = '0;
        if (grant_any) begin
            wb_ready[grant_idx] = 1'b1;
        end
    end

    assign grant_addr = wb_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
    assign grant_data = wb_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    assign ptr_next   = (grant_idx == PTR_W'(NUM_WB - 1)) ? '0 : grant_idx + 1'b1;
    assign err_hit    = grant_any && (grant_addr != '0) && !busy[grant_addr];

    // Clear applied first so that a same-edge set of the same index wins.
    always_comb begin
        busy_next = busy;
        if (rf_wen) begin
            busy_next[rf_waddr] = 1'b0;
        end
        if (set_en) begin
            busy_next[iss_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // Write stage: one registered write per cycle, committed and cleared in the following cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy     <= '0;
            ptr      <= '0;
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            wb_err   <= 1'b0;
        end else begin
            busy   <= busy_next;
            rf_wen <= grant_any && (grant_addr != '0);
            if (grant_any) begin
                ptr      <= ptr_next;
                rf_waddr <= grant_addr;
                rf_wdata <= grant_data;
            end
            if (err_hit) begin
                wb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_scoreboard.sv
// Directed bench for rf_wb_scoreboard: expected register-file writes are queued as
// write-backs are granted and popped when rf_wen fires; hazards and grants are checked inline.
module tb_rf_wb_scoreboard;

    localparam int NW = 2;
    localparam int AW = 5;
    localparam int DW = 64;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                iss_valid;
    logic [AW-1:0]       iss_rs1;
    logic [AW-1:0]       iss_rs2;
    logic [AW-1:0]       iss_rd;
    logic                iss_rd_we;
    logic                iss_ready;
    logic [AW-1:0]       rf_raddr1;
    logic [AW-1:0]       rf_raddr2;
    logic [NW-1:0]       wb_valid;
    logic [NW*AW-1:0]    wb_addr;
    logic [NW*DW-1:0]    wb_data;
    logic [NW-1:0]       wb_ready;
    logic                rf_wen;
    logic [AW-1:0]       rf_waddr;
    logic [DW-1:0]       rf_wdata;
    logic                wb_err;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t e;
    int  errors = 0;
    int  checks = 0;

    always #5 clk = ~clk;

    rf_wb_scoreboard #(.NUM_WB(NW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .iss_valid (iss_valid),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .iss_rd    (iss_rd),
        .iss_rd_we (iss_rd_we),
        .iss_ready (iss_ready),
        .rf_raddr1 (rf_raddr1),
        .rf_raddr2 (rf_raddr2),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_ready  (wb_ready),
        .rf_wen    (rf_wen),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .wb_err    (wb_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_iss(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                           input logic [AW-1:0] rd, input logic we);
        iss_valid = v;
        iss_rs1   = rs1;
        iss_rs2   = rs2;
        iss_rd    = rd;
        iss_rd_we = we;
    endtask

    task automatic set_wb(input logic [NW-1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        wb_valid = v;
        wb_addr  = {a1, a0};
        wb_data  = {d1, d0};
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_q.push_back(w);
    endtask

    // Every register-file write must match the oldest outstanding expected write.
    always @(negedge clk) begin
        if (rf_wen === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", 64'(rf_waddr), 64'hFFFF);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 64'(rf_waddr), 64'(e.a));
                chk("wr_data", rf_wdata, e.d);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        set_iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        set_wb(2'b00, 5'd0, 5'd0, 64'd0, 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_wen", 64'(rf_wen), 64'd0);
        chk("rst_wb_ready", 64'(wb_ready), 64'd0);
        chk("rst_iss_ready", 64'(iss_ready), 64'd1);
        chk("rst_wb_err", 64'(wb_err), 64'd0);
        chk("rst_waddr", 64'(rf_waddr), 64'd0);
        chk("rst_wdata", rf_wdata, 64'd0);

        // RAW: rd=5 issued, consumer stalls until the write-back commits.
        tick(); set_iss(1'b1, 5'd0, 5'd0, 5'd5, 1'b1);
        @(negedge clk); chk("raw_c0_ready", 64'(iss_ready), 64'd1);
        tick(); set_iss(1'b1, 5'd5, 5'd0, 5'd0, 1'b0);
        @(negedge clk); chk("raw_c1_ready", 64'(iss_ready), 64'd0);
        chk("raw_raddr1", 64'(rf_raddr1), 64'd5);
        tick();
        @(negedge clk); chk("raw_c2_ready", 64'(iss_ready), 64'd0);
        tick(); set_wb(2'b01, 5'd5, 5'd0, 64'hDEAD, 64'd0); push(5'd5, 64'hDEAD);
        @(negedge clk); chk("raw_c3_grant", 64'(wb_ready), 64'd1);
        chk("raw_c3_ready", 64'(iss_ready), 64'd0);
        tick(); set_wb(2'b00, 5'd0, 5'd0, 64'd0, 64'd0);
        @(negedge clk); chk("raw_c4_wen", 64'(rf_wen), 64'd1);
        chk("raw_c4_ready", 64'(iss_ready), 64'd0);
        tick();
        @(negedge clk); chk("raw_c5_ready", 64'(iss_ready), 64'd1);
        chk("raw_c5_err", 64'(wb_err), 64'd0);

        // x0 write-back from requester 1 (ptr is 1 here): consumed, never written.
        tick(); set_iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        set_wb(2'b10, 5'd0, 5'd0, 64'd0, 64'h1234);
        @(negedge clk); chk("x0_grant", 64'(wb_ready), 64'd2);
        tick(); set_wb(2'b00, 5'd0, 5'd0, 64'd0, 64'd0);
        @(negedge clk); chk("x0_wen", 64'(rf_wen), 64'd0);
        chk("x0_err", 64'(wb_err), 64'd0);

        // Round-robin: reserve r10..r13, then two requesters contend for 4 cycles.
        for (int i = 0; i < 4; i++) begin
            tick(); set_iss(1'b1, 5'd0, 5'd0, 5'(10 + i), 1'b1);
            @(negedge clk); chk("rr_issue_ready", 64'(iss_ready), 64'd1);
        end
        tick(); set_iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        set_wb(2'b11, 5'd10, 5'd11, 64'hA0, 64'hA1); push(5'd10, 64'hA0);
        @(negedge clk); chk("rr_g0", 64'(wb_ready), 64'd1);
        tick(); set_wb(2'b11, 5'd12, 5'd11, 64'hA2, 64'hA1); push(5'd11, 64'hA1);
        @(negedge clk); chk("rr_g1", 64'(wb_ready), 64'd2);
        tick(); set_wb(2'b11, 5'd12, 5'd13, 64'hA2, 64'hA3); push(5'd12, 64'hA2);
        @(negedge clk); chk("rr_g2", 64'(wb_ready), 64'd1);
        tick(); set_wb(2'b11, 5'd14, 5'd13, 64'hA4, 64'hA3); push(5'd13, 64'hA3);
        @(negedge clk); chk("rr_g3", 64'(wb_ready), 64'd2);
        tick(); set_wb(2'b00, 5'd0, 5'd0, 64'd0, 64'd0);
        @(negedge clk); chk("rr_err", 64'(wb_err), 64'd0);
        tick(); set_iss(1'b1, 5'd10, 5'd13, 5'd0, 1'b0);
        @(negedge clk); chk("rr_cleared_ready", 64'(iss_ready), 64'd1);

        // WAW on r7, plus x0 sources/destinations never stalling.
        tick(); set_iss(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
        @(negedge clk); chk("waw_first", 64'(iss_ready), 64'd1);
        tick();
        @(negedge clk); chk("waw_stall", 64'(iss_ready), 64'd0);
        tick(); set_iss(1'b1, 5'd0, 5'd0, 5'd0, 1'b1);
        @(negedge clk); chk("rd0_no_stall", 64'(iss_ready), 64'd1);
        tick(); set_iss(1'b1, 5'd0, 5'd0, 5'd7, 1'b1);
        set_wb(2'b01, 5'd7, 5'd0, 64'h77, 64'd0); push(5'd7, 64'h77);
        @(negedge clk); chk("waw_grant", 64'(wb_ready), 64'd1);
        chk("waw_g_ready", 64'(iss_ready), 64'd0);
        tick(); set_wb(2'b00, 5'd0, 5'd0, 64'd0, 64'd0);
        @(negedge clk); chk("waw_g1_ready", 64'(iss_ready), 64'd0);
        tick();
        @(negedge clk); chk("waw_release", 64'(iss_ready), 64'd1);
        tick(); set_iss(1'b1, 5'd7, 5'd0, 5'd0, 1'b0);
        @(negedge clk); chk("raw7_after_reissue", 64'(iss_ready), 64'd0);
        tick(); set_iss(1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
        @(negedge clk); chk("rs0_no_stall", 64'(iss_ready), 64'd1);

        // Error: write-back to idle r9 via requester 1 (ptr is 1 here).
        tick(); set_iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        set_wb(2'b10, 5'd0, 5'd9, 64'd0, 64'h99); push(5'd9, 64'h99);
        @(negedge clk); chk("err_grant", 64'(wb_ready), 64'd2);
        chk("err_before", 64'(wb_err), 64'd0);
        tick(); set_wb(2'b00, 5'd0, 5'd0, 64'd0, 64'd0);
        @(negedge clk); chk("err_set", 64'(wb_err), 64'd1);
        repeat (2) begin
            tick();
            @(negedge clk); chk("err_sticky", 64'(wb_err), 64'd1);
        end

        // Reset during a grant cycle: staged write dropped, reservations and pointer cleared.
        tick(); rst_n = 1'b0; set_wb(2'b01, 5'd7, 5'd0, 64'h55, 64'd0);
        @(negedge clk); chk("rstmid_grant", 64'(wb_ready), 64'd1);
        tick(); rst_n = 1'b1; set_wb(2'b00, 5'd0, 5'd0, 64'd0, 64'd0);
        set_iss(1'b1, 5'd7, 5'd0, 5'd7, 1'b1);
        @(negedge clk); chk("rstmid_wen", 64'(rf_wen), 64'd0);
        chk("rstmid_waddr", 64'(rf_waddr), 64'd0);
        chk("rstmid_err", 64'(wb_err), 64'd0);
        chk("rstmid_busy_clear", 64'(iss_ready), 64'd1);
        tick(); set_iss(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        set_wb(2'b11, 5'd0, 5'd0, 64'd1, 64'd2);
        @(negedge clk); chk("rstmid_ptr0", 64'(wb_ready), 64'd1);
        tick(); set_wb(2'b00, 5'd0, 5'd0, 64'd0, 64'd0);
        @(negedge clk); chk("rstmid_x0_wen", 64'(rf_wen), 64'd0);
        tick();
        @(negedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
